rst_sequencer: RTL

Reset sequencer that releases several downstream reset domains in fixed order after the chip-level reset deasserts. Domains are released one at a time with a programmable gap, so the PE array, buffers and interconnect leave reset in a defined order. A software reset request can re-enter the full sequence at runtime. It sits directly behind the synchronized top-level reset and drives the per-domain reset inputs of the accelerator.

---
 rtl/rst_seq_pkg.sv | 14 +
 rtl/rst_sequencer.sv | 132 +++++++++++++
 2 files changed

// File: rtl/rst_seq_pkg.sv
// Shared types and default parameters for the reset sequencer.
package rst_seq_pkg;

  typedef enum logic [1:0] {
    HOLD    = 2'd0,
    RELEASE = 2'd1,
    RUN     = 2'd2
  } state_e;

  localparam int unsigned DefNumDomains = 4;
  localparam int unsigned DefHoldCycles = 16;
  localparam int unsigned DefGapCycles  = 4;

endpackage

// File: rtl/rst_sequencer.sv
// Releases downstream reset domains one by one after chip reset deasserts;
// a software request in RUN re-enters the whole sequence.
module rst_sequencer
  import rst_seq_pkg::*;
#(
  parameter int unsigned NumDomains = DefNumDomains,
  parameter int unsigned HoldCycles = DefHoldCycles,
  parameter int unsigned GapCycles  = DefGapCycles
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  sw_rst_req_i,
  output logic                  sw_rst_ack_o,
  output logic [NumDomains-1:0] rst_no,
  output logic                  done_o,
  output logic                  busy_o
);

  localparam int unsigned MaxCnt = (HoldCycles > GapCycles) ? HoldCycles : GapCycles;
  localparam int unsigned CntW   = $clog2(MaxCnt + 1);
  localparam int unsigned IdxW   = $clog2(NumDomains + 1);

  if (NumDomains == 0) begin : gen_chk_domains
    $error("NumDomains must be at least 1");
  end
  if (HoldCycles == 0) begin : gen_chk_hold
    $error("HoldCycles must be at least 1");
  end
  if (GapCycles == 0) begin : gen_chk_gap
    $error("GapCycles must be at least 1");
  end

  state_e                state_q, state_d;
  logic [CntW-1:0]       cnt_q, cnt_d;
  logic [IdxW-1:0]       idx_q, idx_d;
  logic [NumDomains-1:0] rst_q, rst_d;
  logic                  done_q, done_d;
  logic                  busy_q, busy_d;
  logic                  ack_q, ack_d;

  // State and registered outputs
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= HOLD;
      cnt_q   <= '0;
      idx_q   <= '0;
      rst_q   <= '0;
      done_q  <= 1'b0;
      busy_q  <= 1'b1;
      ack_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      rst_q   <= rst_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
      ack_q   <= ack_d;
    end
  end

  // Next-state and next-output logic
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    rst_d   = rst_q;
    done_d  = done_q;
    busy_d  = busy_q;
    ack_d   = 1'b0;

    unique case (state_q)
      HOLD: begin
        cnt_d = cnt_q + CntW'(1);
        if (cnt_q == CntW'(HoldCycles - 1)) begin
          rst_d[0] = 1'b1;
          cnt_d    = '0;
          idx_d    = IdxW'(1);
          if (NumDomains == 1) begin
            state_d = RUN;
            done_d  = 1'b1;
            busy_d  = 1'b0;
          end else begin
            state_d = RELEASE;
          end
        end
      end

      RELEASE: begin
        cnt_d = cnt_q + CntW'(1);
        if (cnt_q == CntW'(GapCycles - 1)) begin
          rst_d = rst_q | (NumDomains'(1) << idx_q);
          cnt_d = '0;
          idx_d = idx_q + IdxW'(1);
          if (idx_q == IdxW'(NumDomains - 1)) begin
            state_d = RUN;
            done_d  = 1'b1;
            busy_d  = 1'b0;
          end
        end
      end

      RUN: begin
        // Software reset re-asserts every domain at once and restarts the hold
        if (sw_rst_req_i) begin
          state_d = HOLD;
          cnt_d   = '0;
          idx_d   = '0;
          rst_d   = '0;
          done_d  = 1'b0;
          busy_d  = 1'b1;
          ack_d   = 1'b1;
        end
      end

      default: begin
        state_d = HOLD;
        cnt_d   = '0;
        idx_d   = '0;
        rst_d   = '0;
        done_d  = 1'b0;
        busy_d  = 1'b1;
      end
    endcase
  end

  assign rst_no       = rst_q;
  assign done_o       = done_q;
  assign busy_o       = busy_q;
  assign sw_rst_ack_o = ack_q;

endmodule
